// File: rtl/prog_loader.sv
// prog_loader: UART boot loader. Receives an 8N1 byte stream, waits for a sync
// marker, then packs following bytes little-endian into 32-bit words and writes
// them to instruction memory from address 0 up to MEM_SIZE-4.
module prog_loader #(
    parameter int         CLKS_PER_BIT = 434,
    parameter int         MEM_SIZE     = 64,
    parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        uart_rx,
    output logic        wr_en,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data,
    output logic        busy,
    output logic        done,
    output logic        frame_err
);

    localparam int               CNT_W     = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [31:0]      LAST_ADDR = 32'(MEM_SIZE - 4);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;
    typedef enum logic {WAIT_SYNC, LOAD} ld_state_t;

    logic             rx_meta;
    logic             rx_sync;
    rx_state_t        rx_state;
    rx_state_t        rx_next;
    logic [CNT_W-1:0] clk_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       rx_shift;
    logic             half_tick;
    logic             bit_tick;
    logic             byte_ok;
    logic             byte_bad;
    logic             sync_hit;

    ld_state_t        ld_state;
    ld_state_t        ld_next;
    logic [31:0]      addr;
    logic [1:0]       lane;
    logic [23:0]      word_buf;
    logic             last_word;

    assign half_tick = (clk_cnt == HALF_LAST);
    assign bit_tick  = (clk_cnt == BIT_LAST);

    // A byte completes on the stop-bit sample edge; the line level there decides
    // whether it is a good byte or a framing error.
    assign byte_ok   = (rx_state == STOP) && bit_tick && rx_sync;
    assign byte_bad  = (rx_state == STOP) && bit_tick && !rx_sync;
    assign sync_hit  = byte_ok && (rx_shift == SYNC_BYTE);
    assign last_word = (lane == 2'd3) && (addr == LAST_ADDR);

    // Two-flop synchronizer; resets to the idle-high line level.
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= uart_rx;
            rx_sync <= rx_meta;
        end
    end

    // Receiver state register.
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            rx_state <= IDLE;
        end else begin
            rx_state <= rx_next;
        end
    end

    // Receiver next-state: half-bit check of the start bit rejects short glitches.
    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            IDLE:    if (!rx_sync) rx_next = START;
            START:   if (half_tick) rx_next = rx_sync ? IDLE : DATA;
            DATA:    if (bit_tick && (bit_idx == 3'd7)) rx_next = STOP;
            STOP:    if (bit_tick) rx_next = IDLE;
            default: rx_next = IDLE;
        endcase
    end

    // Receiver datapath: bit-period counter, bit index and LSB-first shift register.
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            clk_cnt  <= '0;
            bit_idx  <= 3'd0;
            rx_shift <= 8'd0;
        end else begin
            case (rx_state)
                IDLE: begin
                    clk_cnt <= '0;
                    bit_idx <= 3'd0;
                end
                START: begin
                    clk_cnt <= half_tick ? '0 : clk_cnt + 1'b1;
                end
                DATA: begin
                    if (bit_tick) begin
                        clk_cnt  <= '0;
                        rx_shift <= {rx_sync, rx_shift[7:1]};
                        bit_idx  <= bit_idx + 3'd1;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                STOP: begin
                    clk_cnt <= bit_tick ? '0 : clk_cnt + 1'b1;
                end
                default: begin
                    clk_cnt <= '0;
                end
            endcase
        end
    end

    // Loader state register.
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            ld_state <= WAIT_SYNC;
        end else begin
            ld_state <= ld_next;
        end
    end

    // Loader next-state: leave LOAD on a framing error or after the final word.
    always_comb begin
        ld_next = ld_state;
        case (ld_state)
            WAIT_SYNC: if (sync_hit) ld_next = LOAD;
            LOAD: begin
                if (byte_bad) begin
                    ld_next = WAIT_SYNC;
                end else if (byte_ok && last_word) begin
                    ld_next = WAIT_SYNC;
                end
            end
            default: ld_next = WAIT_SYNC;
        endcase
    end

    // Loader datapath: word assembly, write strobe, address advance and status flags.
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            wr_en     <= 1'b0;
            wr_addr   <= 32'd0;
            wr_data   <= 32'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            frame_err <= 1'b0;
            addr      <= 32'd0;
            lane      <= 2'd0;
            word_buf  <= 24'd0;
        end else begin
            wr_en <= 1'b0;
            done  <= 1'b0;
            case (ld_state)
                WAIT_SYNC: begin
                    if (sync_hit) begin
                        busy      <= 1'b1;
                        frame_err <= 1'b0;
                        addr      <= 32'd0;
                        lane      <= 2'd0;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                LOAD: begin
                    if (byte_bad) begin
                        frame_err <= 1'b1;
                        busy      <= 1'b0;
                    end else if (byte_ok) begin
                        lane <= lane + 2'd1;
                        case (lane)
                            2'd0: word_buf[7:0]   <= rx_shift;
                            2'd1: word_buf[15:8]  <= rx_shift;
                            2'd2: word_buf[23:16] <= rx_shift;
                            default: begin
                                wr_en   <= 1'b1;
                                wr_addr <= addr;
                                wr_data <= {rx_shift, word_buf};
                                if (addr == LAST_ADDR) begin
                                    done <= 1'b1;
                                end else begin
                                    addr <= addr + 32'd4;
                                end
                            end
                        endcase
                    end
                end
                default: begin
                    busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed bench for the UART program loader with a short bit
// period; drives serial frames and checks the logged memory writes and flags.
module tb_prog_loader;

    localparam int CPB = 8;
    localparam int MEM = 64;

    logic        sys_clk;
    logic        sys_rst;
    logic        uart_rx;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        busy;
    logic        done;
    logic        frame_err;

    int errors;
    int checks;

    logic [31:0] log_addr[$];
    logic [31:0] log_data[$];
    int          done_cnt;
    int          done_alone;

    prog_loader #(
        .CLKS_PER_BIT(CPB),
        .MEM_SIZE    (MEM),
        .SYNC_BYTE   (8'hA5)
    ) dut (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .uart_rx  (uart_rx),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .busy     (busy),
        .done     (done),
        .frame_err(frame_err)
    );

    // Free-running 100 MHz-style clock.
    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // Write monitor: records every strobed write and where done pulses land.
    always @(negedge sys_clk) begin
        if (wr_en) begin
            log_addr.push_back(wr_addr);
            log_data.push_back(wr_data);
        end
        if (done) begin
            done_cnt++;
            if (!wr_en) done_alone++;
        end
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        log_addr.delete();
        log_data.delete();
        done_cnt   = 0;
        done_alone = 0;
    endtask

    task automatic hold_line(input logic v, input int n);
        uart_rx = v;
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        hold_line(1'b0, CPB);
        for (int i = 0; i < 8; i++) hold_line(b[i], CPB);
        hold_line(stop_bit, CPB);
        uart_rx = 1'b1;
    endtask

    function automatic logic [31:0] log_addr_at(input int idx);
        return (idx < log_addr.size()) ? log_addr[idx] : 32'hDEADBEEF;
    endfunction

    function automatic logic [31:0] log_data_at(input int idx);
        return (idx < log_data.size()) ? log_data[idx] : 32'hDEADBEEF;
    endfunction

    task automatic check_all_zero(input string tag);
        check_output({tag, "_wr_en"},     32'(wr_en),     32'd0);
        check_output({tag, "_wr_addr"},   wr_addr,        32'd0);
        check_output({tag, "_wr_data"},   wr_data,        32'd0);
        check_output({tag, "_busy"},      32'(busy),      32'd0);
        check_output({tag, "_done"},      32'(done),      32'd0);
        check_output({tag, "_frame_err"}, 32'(frame_err), 32'd0);
    endtask

    // Directed test sequence.
    initial begin
        logic [7:0] b;
        errors  = 0;
        checks  = 0;
        uart_rx = 1'b1;
        sys_rst = 1'b0;
        clear_log();
        repeat (3) @(negedge sys_clk);
        check_all_zero("reset");

        sys_rst = 1'b1;
        clear_log();
        repeat (1000) @(negedge sys_clk);
        check_output("idle_writes", 32'(log_addr.size()), 32'd0);
        check_output("idle_busy",   32'(busy),            32'd0);

        $display("[TB] full load with bytes 00..3F");
        send_byte(8'hA5, 1'b1);
        check_output("sync_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 64; i++) send_byte(8'(i), 1'b1);
        repeat (4) @(negedge sys_clk);
        check_output("load_writes",     32'(log_addr.size()), 32'd16);
        check_output("load_done_cnt",   32'(done_cnt),        32'd1);
        check_output("load_done_alone", 32'(done_alone),      32'd0);
        check_output("load_busy_after", 32'(busy),            32'd0);
        for (int w = 0; w < 16; w++) begin
            check_output($sformatf("load_addr%0d", w), log_addr_at(w), 32'(4 * w));
            check_output($sformatf("load_data%0d", w), log_data_at(w),
                         {8'(4 * w + 3), 8'(4 * w + 2), 8'(4 * w + 1), 8'(4 * w)});
        end
        check_output("hold_wr_en",   32'(wr_en), 32'd0);
        check_output("hold_wr_addr", wr_addr,    32'd60);
        check_output("hold_wr_data", wr_data,    32'h3F3E3D3C);

        $display("[TB] bytes without sync");
        clear_log();
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b1);
        repeat (100) @(negedge sys_clk);
        check_output("nosync_writes", 32'(log_addr.size()), 32'd0);
        check_output("nosync_busy",   32'(busy),            32'd0);

        $display("[TB] start-bit glitch while idle");
        hold_line(1'b0, 2);
        hold_line(1'b1, 100);
        check_output("glitch_writes",    32'(log_addr.size()), 32'd0);
        check_output("glitch_busy",      32'(busy),            32'd0);
        check_output("glitch_frame_err", 32'(frame_err),       32'd0);

        $display("[TB] glitch inside frame, then framing error");
        send_byte(8'hA5, 1'b1);
        hold_line(1'b0, 2);
        hold_line(1'b1, 3 * CPB);
        check_output("lglitch_busy",      32'(busy),      32'd1);
        check_output("lglitch_frame_err", 32'(frame_err), 32'd0);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b1);
        send_byte(8'h44, 1'b1);
        send_byte(8'h55, 1'b1);
        send_byte(8'h66, 1'b0);
        hold_line(1'b1, 3 * CPB);
        check_output("ferr_writes",    32'(log_addr.size()), 32'd1);
        check_output("ferr_addr",      log_addr_at(0),       32'd0);
        check_output("ferr_data",      log_data_at(0),       32'h44332211);
        check_output("ferr_frame_err", 32'(frame_err),       32'd1);
        check_output("ferr_busy",      32'(busy),            32'd0);

        send_byte(8'hA5, 1'b1);
        check_output("resync_frame_err", 32'(frame_err), 32'd0);
        check_output("resync_busy",      32'(busy),      32'd1);
        clear_log();
        send_byte(8'hAA, 1'b1);
        send_byte(8'hBB, 1'b1);
        send_byte(8'hCC, 1'b1);
        send_byte(8'hDD, 1'b1);
        repeat (4) @(negedge sys_clk);
        check_output("resync_writes", 32'(log_addr.size()), 32'd1);
        check_output("resync_addr",   log_addr_at(0),       32'd0);
        check_output("resync_data",   log_data_at(0),       32'hDDCCBBAA);

        $display("[TB] reset in the middle of a frame");
        sys_rst = 1'b0;
        repeat (2) @(negedge sys_clk);
        sys_rst = 1'b1;
        repeat (2) @(negedge sys_clk);
        clear_log();
        send_byte(8'hA5, 1'b1);
        for (int i = 0; i < 10; i++) send_byte(8'(8'h40 + i), 1'b1);
        repeat (2) @(negedge sys_clk);
        check_output("pre_rst_writes", 32'(log_addr.size()), 32'd2);
        check_output("pre_rst_data1",  log_data_at(1),       32'h47464544);
        sys_rst = 1'b0;
        #1;
        check_all_zero("midrst");
        repeat (3) @(negedge sys_clk);
        sys_rst = 1'b1;
        clear_log();
        send_byte(8'h01, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h03, 1'b1);
        send_byte(8'h04, 1'b1);
        repeat (10) @(negedge sys_clk);
        check_output("postrst_writes", 32'(log_addr.size()), 32'd0);
        check_output("postrst_busy",   32'(busy),            32'd0);

        send_byte(8'hA5, 1'b1);
        for (int i = 0; i < 64; i++) begin
            b = 8'(i) ^ 8'hA5;
            send_byte(b, 1'b1);
        end
        repeat (4) @(negedge sys_clk);
        check_output("reload_writes",     32'(log_addr.size()), 32'd16);
        check_output("reload_done_cnt",   32'(done_cnt),        32'd1);
        check_output("reload_done_alone", 32'(done_alone),      32'd0);
        check_output("reload_busy",       32'(busy),            32'd0);
        check_output("reload_addr0",      log_addr_at(0),       32'd0);
        check_output("reload_data0",      log_data_at(0),       32'hA6A7A4A5);
        check_output("reload_addr15",     log_addr_at(15),      32'd60);
        check_output("reload_data15",     log_data_at(15),      32'h9A9B9899);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
